// File: rtl/anc_pkg.sv
// Shared ANC datapath definitions: default word width and the sign-magnitude
// word layout used by the adder, multiplier and filter blocks.
package anc_pkg;

   localparam int WIDTH_DEF = 21;
   localparam int MAG_W     = WIDTH_DEF - 1;
   localparam logic [MAG_W-1:0] MAG_MAX = {MAG_W{1'b1}};

   typedef struct packed {
      logic             sign;
      logic [MAG_W-1:0] mag;
   } sm_word_t;

   // Zero magnitude is always reported as +0.
   function automatic sm_word_t sm_canon(input sm_word_t w);
      sm_word_t r;
      r = w;
      if (w.mag == '0) r.sign = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/sm_add_comb.sv
// Combinational sign-magnitude add/subtract with magnitude saturation.
// Suitable as the core of accumulators as well as the registered adder.
module sm_add_comb
   import anc_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             ovf
);

   localparam int MW = WIDTH - 1;

   logic          sa, sb;
   logic [MW-1:0] ma, mb;
   logic [MW:0]   mag_add;
   logic [MW-1:0] mag_r;
   logic          sign_r;

   assign sa      = a[MW];
   assign sb      = b[MW];
   assign ma      = a[MW-1:0];
   assign mb      = b[MW-1:0];
   assign mag_add = {1'b0, ma} + {1'b0, mb};

   always_comb begin
      mag_r  = '0;
      sign_r = 1'b0;
      ovf    = 1'b0;
      if (sa == sb) begin
         sign_r = sa;
         if (mag_add[MW]) begin
            mag_r = {MW{1'b1}};
            ovf   = 1'b1;
         end else begin
            mag_r = mag_add[MW-1:0];
         end
      end else if (ma > mb) begin
         mag_r  = ma - mb;
         sign_r = sa;
      end else if (mb > ma) begin
         mag_r  = mb - ma;
         sign_r = sb;
      end
      // A -0 operand or exact cancellation must never leave a negative zero.
      sum = {(sign_r && (mag_r != '0)), mag_r};
   end

endmodule

// File: rtl/sign_mag_adder.sv
// Registered sign-magnitude adder: one-cycle latency, one result per cycle,
// saturating on magnitude overflow.
module sign_mag_adder
   import anc_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] AddOut,
   output logic             ovf
);

   // Valid protocol: no ready/back-pressure. a/b are captured on every rising
   // edge with in_valid=1; out_valid pulses for exactly the following cycle
   // and AddOut/ovf keep the last result while no new operands arrive.

   logic [WIDTH-1:0] sum_c;
   logic             ovf_c;

   logic [WIDTH-1:0] add_out_d, add_out_q;
   logic             ovf_d, ovf_q;
   logic             out_valid_d, out_valid_q;

   sm_add_comb #(.WIDTH(WIDTH)) u_add (
      .a   (a),
      .b   (b),
      .sum (sum_c),
      .ovf (ovf_c)
   );

   always_comb begin
      add_out_d   = add_out_q;
      ovf_d       = ovf_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         add_out_d = sum_c;
         ovf_d     = ovf_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_out_q   <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         add_out_q   <= add_out_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign AddOut    = add_out_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_mag_adder.sv
// Bench for sign_mag_adder: directed plan cases plus randomized traffic,
// checked against an integer-arithmetic reference model.
module tb_sign_mag_adder;
   import anc_pkg::*;

   localparam int W = WIDTH_DEF;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] a, b;
   logic         out_valid;
   logic [W-1:0] AddOut;
   logic         ovf;

   int total = 0;
   int bad   = 0;

   // Expected {out_valid, ovf, AddOut}, one entry per sampled cycle.
   logic [W+1:0] exp_q[$];
   logic         m_valid;
   logic         m_ovf;
   logic [W-1:0] m_add;

   sign_mag_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .AddOut    (AddOut),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: convert to signed integers, add, saturate the magnitude.
   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
      longint va, vb, s, mag;
      logic   o;
      va  = x[W-1] ? -longint'(x[W-2:0]) : longint'(x[W-2:0]);
      vb  = y[W-1] ? -longint'(y[W-2:0]) : longint'(y[W-2:0]);
      s   = va + vb;
      mag = (s < 0) ? -s : s;
      o   = 1'b0;
      if (mag > longint'(MAG_MAX)) begin
         mag = longint'(MAG_MAX);
         o   = 1'b1;
      end
      return {o, (s < 0), mag[W-2:0]};
   endfunction

   task automatic check_head();
      logic [W+1:0] e;
      if (exp_q.size() == 0) begin
         check("queue_empty", 1, 0);
      end else begin
         e = exp_q.pop_front();
         check("out_valid", out_valid, e[W+1]);
         check("ovf", ovf, e[W]);
         check("AddOut", AddOut, e[W-1:0]);
      end
   endtask

   task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] r;
      @(negedge clk);
      check_head();
      in_valid = v;
      a        = x;
      b        = y;
      m_valid  = v;
      if (v) begin
         r     = ref_add(x, y);
         m_ovf = r[W];
         m_add = r[W-1:0];
      end
      exp_q.push_back({m_valid, m_ovf, m_add});
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_add   = '0;
   endtask

   function automatic logic [W-1:0] rand_operand();
      logic [W-2:0] m;
      case ($urandom_range(0, 3))
         0:       m = W'($urandom_range(0, 3));
         1:       m = MAG_MAX - (W-1)'($urandom_range(0, 3));
         2:       m = (W-1)'($urandom_range(0, 1000));
         default: m = (W-1)'($urandom);
      endcase
      return {1'(($urandom_range(0, 1))), m};
   endfunction

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = W'(5);
      b        = W'(7);
      model_reset();

      // Reset held with in_valid high: outputs stay clear across edges.
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_AddOut", AddOut, 0);
      check("rst_ovf", ovf, 0);

      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      exp_q.push_back('0);

      // Directed plan cases, back-to-back.
      step(1, W'(0),       W'(0));
      step(1, W'(100),     W'(1048576));
      step(1, W'(1048576), W'(1048576));
      step(1, W'(22),      W'(20));
      step(1, W'(1048598), W'(20));
      step(1, W'(22),      W'(1048596));
      step(1, W'(1048576 + 450), W'(1048576 + 234));
      step(1, W'(450),     W'(234));
      step(1, W'(1048576 + 450), W'(234));
      step(1, W'(450),     W'(1048576 + 234));
      step(1, W'(1048598), W'(22));
      step(1, W'(1048575), W'(1));
      step(1, W'(2097151), W'(2097151));
      step(0, W'(3),       W'(4));
      step(0, W'(9),       W'(9));
      @(negedge clk);
      check_head();

      // Absolute spot checks of plan values, independent of the model.
      in_valid = 1'b1;
      a        = W'(1048576 + 450);
      b        = W'(1048576 + 234);
      @(posedge clk);
      #1;
      check("abs_neg684", AddOut, 1049260);
      in_valid = 1'b0;

      // Reset between edges clears outputs without a clock.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_out_valid", out_valid, 0);
      check("async_AddOut", AddOut, 0);
      check("async_ovf", ovf, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back('0);

      // Randomized traffic with idle gaps.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) != 0), rand_operand(), rand_operand());
      end
      @(negedge clk);
      check_head();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
